ft2232h_led_controller: RTL and testbench

FT2232H_LED_CONTROLLER -- requirements
Module: ft2232h_led_controller

---
 rtl/ft2232h_pkg.sv | 18 +
 rtl/ft2232h_led_controller_if.sv | 24 ++
 rtl/ft_burst_counter.sv | 50 +++++
 rtl/ft2232h_led_controller.sv | 106 ++++++++++
 tb/tb_ft2232h_led_controller.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft2232h_pkg.sv
// Shared types and constants for the FT2232H receive-FIFO LED controller.
package ft2232h_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } ft_state_e;

  // FT2232H handshake lines are active-low
  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  localparam int DATA_W         = 8;
  localparam int MAX_BURST_DEF  = 512;
  localparam int GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/ft2232h_led_controller_if.sv
// FT2232H synchronous-FIFO receive handshake: status/data from the chip, read strobe back.
interface ft2232h_led_controller_if;

  logic       rxf_i;
  logic       oe_i;
  logic [7:0] data_i;
  logic       rd_o;

  // master: the FT2232H side (or its model); slave: the controller
  modport master (
    output rxf_i,
    output oe_i,
    output data_i,
    input  rd_o
  );

  modport slave (
    input  rxf_i,
    input  oe_i,
    input  data_i,
    output rd_o
  );

endinterface

// File: rtl/ft_burst_counter.sv
// Burst byte counter with last-beat/terminal flags and the post-burst gap counter.
module ft_burst_counter
  import ft2232h_pkg::*;
#(
  parameter int MAX_BURST  = MAX_BURST_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  input  logic gap_en,
  output logic last_beat,
  output logic tc,
  output logic gap_done
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_BURST);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] burst_cnt;
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      // Saturate at MAX_BURST so the count can never wrap back to zero
      if (clr)
        burst_cnt <= '0;
      else if (inc && (burst_cnt != CNT_FULL))
        burst_cnt <= burst_cnt + CNT_W'(1);

      if (!gap_en || gap_done)
        gap_cnt <= '0;
      else
        gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  assign last_beat = (burst_cnt == CNT_LAST);
  assign tc        = (burst_cnt == CNT_FULL);
  assign gap_done  = gap_en && (gap_cnt == GAP_LAST);

endmodule

// File: rtl/ft2232h_led_controller.sv
// Reads bytes from the FT2232H receive FIFO in bounded bursts and shows them on the LEDs.
// Build option FT_RX_XOR_EN: LEDs show a running XOR of received bytes instead of the last byte.
module ft2232h_led_controller
  import ft2232h_pkg::*;
#(
  parameter int MAX_BURST  = MAX_BURST_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ft2232h_led_controller_if.slave ft,
  output logic [DATA_W-1:0]       led_r
);

  ft_state_e state;
  logic      rd_q;

  logic read_ok;
  logic capture;
  logic read_abort;
  logic gap_en;
  logic burst_clr;
  logic last_beat;
  logic tc;
  logic gap_done;

  // A byte is taken only while the strobe is already low and the chip still has data
  always_comb begin
    read_ok    = (rd_q == ASSERT_N) && (ft.rxf_i == ASSERT_N) && (ft.oe_i == ASSERT_N);
    capture    = 1'b0;
    read_abort = 1'b0;
    if (state == READ && !tc) begin
      capture    = read_ok;
      read_abort = !read_ok;
    end
    gap_en    = (state == GAP);
    burst_clr = read_abort || gap_done;
  end

  ft_burst_counter #(
    .MAX_BURST  (MAX_BURST),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_burst_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc       (capture),
    .clr       (burst_clr),
    .gap_en    (gap_en),
    .last_beat (last_beat),
    .tc        (tc),
    .gap_done  (gap_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      rd_q  <= DEASSERT_N;
      led_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_q <= DEASSERT_N;
          if (ft.rxf_i == ASSERT_N && ft.oe_i == ASSERT_N) begin
            state <= READ;
            rd_q  <= ASSERT_N;
          end
        end

        READ: begin
          if (tc) begin
            state <= GAP;
            rd_q  <= DEASSERT_N;
          end else if (capture) begin
`ifdef FT_RX_XOR_EN
            led_r <= led_r ^ ft.data_i;
`else
            led_r <= ft.data_i;
`endif
            // The limit wins over a same-edge rxf rise: the burst ends in GAP
            if (last_beat) begin
              state <= GAP;
              rd_q  <= DEASSERT_N;
            end
          end else begin
            state <= IDLE;
            rd_q  <= DEASSERT_N;
          end
        end

        GAP: begin
          rd_q <= DEASSERT_N;
          if (gap_done)
            state <= IDLE;
        end

        default: begin
          state <= IDLE;
          rd_q  <= DEASSERT_N;
        end
      endcase
    end
  end

  assign ft.rd_o = rd_q;

endmodule

// File: tb/tb_ft2232h_led_controller.sv
// Directed bench for ft2232h_led_controller built with MAX_BURST=4, GAP_CYCLES=2.
module tb_ft2232h_led_controller;

  logic       clk;
  logic       rst;
  logic [7:0] led;
  logic [7:0] exp_led;
  int         n_cmp;
  int         n_bad;

  ft2232h_led_controller_if bus ();

  ft2232h_led_controller #(
    .MAX_BURST  (4),
    .GAP_CYCLES (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ft    (bus),
    .led_r (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_cap(input logic [7:0] cur, input logic [7:0] d);
`ifdef FT_RX_XOR_EN
    return cur ^ d;
`else
    return d;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rxf_i = 1'b1;
    bus.oe_i = 1'b1;
    bus.data_i = 8'h00;
    #20;
    n_cmp++;
    if (bus.rd_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_rd: got %b want 1", bus.rd_o);
    end
    n_cmp++;
    if (led !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_led: got %h want 00", led);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.rd_o !== 1'b1) begin
        n_bad++;
        $display("FAIL idle_rxf_high[%0d]: rd_o got %b want 1", i, bus.rd_o);
      end
    end
    exp_led = 8'h00;
  endtask

  task automatic test_burst();
    bus.rxf_i = 1'b0;
    bus.oe_i = 1'b1;
    bus.data_i = 8'hA5;
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b1) begin
      n_bad++;
      $display("FAIL oe_wait_rd: got %b want 1", bus.rd_o);
    end
    bus.oe_i = 1'b0;
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_fall: got %b want 0", bus.rd_o);
    end
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL no_cap_on_entry: led got %h want %h", led, exp_led);
    end
    step();
    exp_led = model_cap(exp_led, 8'hA5);
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL cap_a5: led got %h want %h", led, exp_led);
    end
    bus.data_i = 8'h3C;
    step();
    exp_led = model_cap(exp_led, 8'h3C);
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL cap_3c: led got %h want %h", led, exp_led);
    end
    bus.data_i = 8'hFF;
    step();
    exp_led = model_cap(exp_led, 8'hFF);
    n_cmp++;
`ifdef FT_RX_XOR_EN
    if (led !== 8'h66) begin
      n_bad++;
      $display("FAIL burst_final: led got %h want 66", led);
    end
`else
    if (led !== 8'hFF) begin
      n_bad++;
      $display("FAIL burst_final: led got %h want ff", led);
    end
`endif
    bus.rxf_i = 1'b1;
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rxf_exit_rd: got %b want 1", bus.rd_o);
    end
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL rxf_exit_led: got %h want %h", led, exp_led);
    end
  endtask

  task automatic test_rxf_rise();
    bus.rxf_i = 1'b0;
    bus.oe_i = 1'b0;
    bus.data_i = 8'h11;
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_fall_rd: got %b want 0", bus.rd_o);
    end
    step();
    exp_led = model_cap(exp_led, 8'h11);
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL cap_11: led got %h want %h", led, exp_led);
    end
    bus.rxf_i = 1'b1;
    bus.data_i = 8'h22;
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rise_rd: got %b want 1", bus.rd_o);
    end
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL rise_led: got %h want %h", led, exp_led);
    end
    bus.data_i = 8'h33;
    step();
    bus.data_i = 8'h44;
    step();
    n_cmp++;
    if (led !== exp_led || bus.rd_o !== 1'b1) begin
      n_bad++;
      $display("FAIL late_data: led/rd got %h/%b want %h/1", led, bus.rd_o, exp_led);
    end
  endtask

  task automatic test_max_burst();
    logic [7:0] d;
    bus.rxf_i = 1'b0;
    bus.oe_i = 1'b0;
    bus.data_i = 8'h10;
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_start_rd: got %b want 0", bus.rd_o);
    end
    for (int k = 0; k < 4; k++) begin
      d = 8'((k + 1) * 16);
      step();
      exp_led = model_cap(exp_led, d);
      n_cmp++;
      if (led !== exp_led) begin
        n_bad++;
        $display("FAIL max_cap[%0d]: led got %h want %h", k, led, exp_led);
      end
      n_cmp++;
      if (bus.rd_o !== ((k == 3) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL max_rd[%0d]: got %b want %b", k, bus.rd_o, (k == 3) ? 1'b1 : 1'b0);
      end
      bus.data_i = 8'((k + 2) * 16);
    end
    for (int g = 0; g < 2; g++) begin
      step();
      n_cmp++;
      if (bus.rd_o !== 1'b1 || led !== exp_led) begin
        n_bad++;
        $display("FAIL gap[%0d]: rd/led got %b/%h want 1/%h", g, bus.rd_o, led, exp_led);
      end
    end
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b0 || led !== exp_led) begin
      n_bad++;
      $display("FAIL reread_rd: rd/led got %b/%h want 0/%h", bus.rd_o, led, exp_led);
    end
    step();
    exp_led = model_cap(exp_led, 8'h50);
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL reread_cap: led got %h want %h", led, exp_led);
    end
    bus.rxf_i = 1'b1;
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b1) begin
      n_bad++;
      $display("FAIL max_exit_rd: got %b want 1", bus.rd_o);
    end
  endtask

  task automatic test_reset_mid_read();
    bus.rxf_i = 1'b0;
    bus.oe_i = 1'b0;
    bus.data_i = 8'h5A;
    step();
    step();
    exp_led = model_cap(exp_led, 8'h5A);
    n_cmp++;
    if (led !== exp_led || bus.rd_o !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_rst_cap: led/rd got %h/%b want %h/0", led, bus.rd_o, exp_led);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_led = 8'h00;
    n_cmp++;
    if (bus.rd_o !== 1'b1) begin
      n_bad++;
      $display("FAIL async_rd: got %b want 1", bus.rd_o);
    end
    n_cmp++;
    if (led !== 8'h00) begin
      n_bad++;
      $display("FAIL async_led: got %h want 00", led);
    end
    step();
    rst = 1'b0;
    bus.data_i = 8'h6B;
    #1;
    n_cmp++;
    if (bus.rd_o !== 1'b1 || led !== 8'h00) begin
      n_bad++;
      $display("FAIL post_rst: rd/led got %b/%h want 1/00", bus.rd_o, led);
    end
    step();
    n_cmp++;
    if (bus.rd_o !== 1'b0 || led !== 8'h00) begin
      n_bad++;
      $display("FAIL fresh_eval: rd/led got %b/%h want 0/00", bus.rd_o, led);
    end
    step();
    exp_led = model_cap(exp_led, 8'h6B);
    n_cmp++;
    if (led !== exp_led) begin
      n_bad++;
      $display("FAIL post_rst_cap: led got %h want %h", led, exp_led);
    end
  endtask

  task automatic test_oe_high();
    bus.oe_i = 1'b1;
    bus.data_i = 8'h77;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (bus.rd_o !== 1'b1 || led !== exp_led) begin
        n_bad++;
        $display("FAIL oe_high[%0d]: rd/led got %b/%h want 1/%h", i, bus.rd_o, led, exp_led);
      end
      bus.data_i = bus.data_i + 8'h13;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_led = 8'h00;
    test_reset();
    test_burst();
    test_rxf_rise();
    test_max_burst();
    test_reset_mid_read();
    test_oe_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
